sample_index_streamer: RTL and testbench
========================================

Name: sample_index_streamer

Overview:
- Transmit end of the sample/index stream that the delay beamformer consumes.
- Reads captured channel samples from a sample RAM with a fixed read latency.
- Presents each sample with a monotonically increasing 16-bit index and drives the beamformer's start strobe.
- Counts the data_good pulses returned by the beamformer, so the controller knows how many delay taps were selected per pass.

Parameters:
- NUM_SAMPLES, 1024: samples per pass; indices 0..NUM_SAMPLES-1.
- ADDR_W, 10: sample RAM address width; NUM_SAMPLES <= 2**ADDR_W.
- RAM_LATENCY, 2: cycles from sample_addr to valid sample_data (1..4).
- HOLD_CYCLES, 1: cycles each index is held on output_value/output_index (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a pass when IDLE or DONE
- sample_addr  out  ADDR_W  sample RAM read address
- sample_data  in  32  sample RAM read data, RAM_LATENCY cycles after address
- output_value  out  32  sample presented to the beamformer
- output_index  out  16  index of output_value; 16'hFFFF when not streaming
- startbeamformer  out  1  high while the stream is valid, plus a drain cycle
- data_good  in  1  beamformer match strobe (registered on its side)
- select_count  out  16  number of data_good cycles seen this pass, saturating
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values: sample_addr=0, output_value=0, output_index=16'hFFFF, startbeamformer=0, select_count=0, busy=0, done=0; state=IDLE; read-valid pipeline cleared.
- Reset mid-pass aborts immediately to the reset values. No partial pass resumes.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE/DONE + start:
  - go to STREAM, clear select_count, issue address 0 in the first STREAM cycle.
  - A start that coincides with a done pulse is accepted.
- STREAM, issue side:
  - One address is issued per HOLD_CYCLES cycles: 0,1,...,NUM_SAMPLES-1.
  - Each issue enters a RAM_LATENCY-deep valid/index shift pipeline.
  - No address is issued after NUM_SAMPLES-1.
  - sample_addr holds its last value between issues.
- STREAM, output side:
  - When a pipeline entry emerges, register output_value<=sample_data and output_index<=its index.
  - Both hold for exactly HOLD_CYCLES cycles.
  - Consecutive indices differ by exactly 1. The index never repeats back-to-back, so the beamformer's change detection fires once per index.
- First output: index 0 appears RAM_LATENCY+1 cycles after the cycle start is sampled high. startbeamformer rises in that same cycle.
- STREAM→DRAIN: when the final index NUM_SAMPLES-1 has completed its HOLD_CYCLES.
- DRAIN, one cycle:
  - output_value/output_index keep the final sample.
  - startbeamformer stays 1, so the beamformer's registered data_good for the last index is captured.
- DRAIN→DONE:
  - startbeamformer=0, output_index=16'hFFFF, output_value=0, busy=0.
  - done=1 for one cycle; select_count frozen.
- select_count:
  - Increments on every cycle with data_good=1 while busy=1, including the DRAIN cycle.
  - Saturates at 16'hFFFF.
  - data_good outside busy is ignored.
- start while busy is ignored.
- Index arithmetic is 16-bit unsigned. NUM_SAMPLES > 65535 is illegal; flag it with an elaboration-time check.

Optional Feature:
- Macro: SAMPLE_STREAMER_WRAP_EN.
- When defined, the pass is continuous:
  - after index NUM_SAMPLES-1 the issue side restarts at address 0 with no gap;
  - output_index wraps to 0, and the 16'hFFFF idle value is never shown between passes;
  - startbeamformer stays high;
  - done pulses once per wrap, in the cycle index 0 of the next pass is presented;
  - select_count clears in that same cycle, with that cycle's data_good counted fresh;
  - DRAIN/DONE are reached only by reset.
- When undefined: single pass ending in DONE as described above.

Test Plan:
1. NUM_SAMPLES=8, HOLD_CYCLES=1, RAM_LATENCY=2, RAM returns addr*3; start pulse at cycle 0 → output_index 0..7 on cycles 3..10, output_value 0,3,..,21; startbeamformer high cycles 3..11; done pulse cycle 12; output_index=16'hFFFF from cycle 12.
2. Same config, HOLD_CYCLES=3 → each index held exactly 3 cycles, indices 0..7 over cycles 3..26; sample_addr advances every 3 cycles; done on cycle 28.
3. data_good driven high one cycle after indices 2, 5 and 7 (the last lands in DRAIN), plus one pulse in IDLE → select_count=3 at done.
4. Reset asserted while output_index=4 → next cycle all outputs at reset values; a later start restarts from index 0 with select_count=0.
5. start re-pulsed at cycle 6 mid-pass → ignored, sequence identical to scenario 1; start on the done cycle → new pass, index 0 appears 3 cycles later.
6. With SAMPLE_STREAMER_WRAP_EN, NUM_SAMPLES=4 → output_index 0,1,2,3,0,1,... on consecutive cycles; done pulses at each index-0 after the first; startbeamformer never drops.

Source files
------------

// File: rtl/sample_index_streamer.sv
// sample_index_streamer: transmit end of the sample/index stream feeding the
// delay beamformer. Reads samples from a fixed-latency sample RAM, presents
// each one with a 16-bit index, drives the beamformer start strobe and counts
// the data_good strobes returned during a pass.
// Optional build macro: SAMPLE_STREAMER_WRAP_EN -- continuous streaming that
// wraps back to index 0 instead of ending in DRAIN/DONE.
module sample_index_streamer #(
    parameter int NUM_SAMPLES = 1024,
    parameter int ADDR_W      = 10,
    parameter int RAM_LATENCY = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sample_addr,
    input  logic [31:0]       sample_data,
    output logic [31:0]       output_value,
    output logic [15:0]       output_index,
    output logic              startbeamformer,
    input  logic              data_good,
    output logic [15:0]       select_count,
    output logic              busy,
    output logic              done
);

    localparam int          DATA_W    = 32;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_SAMPLES - 1);
    localparam logic [15:0] IDLE_IDX  = 16'hFFFF;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    // Elaboration-time parameter legality
    if (NUM_SAMPLES > 65535) begin : g_bad_num_samples
        $error("NUM_SAMPLES must not exceed 65535 (16-bit index)");
    end
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > (2 ** ADDR_W)) begin : g_bad_addr_w
        $error("NUM_SAMPLES must be 1..2**ADDR_W");
    end
    if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_range
        $error("ADDR_W must be 1..16");
    end
    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
        $error("RAM_LATENCY must be 1..4");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65536) begin : g_bad_hold
        $error("HOLD_CYCLES must be 1..65536");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   value_q;
    logic [15:0]         index_q;
    logic                sbf_q;
    logic [15:0]         count_q;
    logic                busy_q;
    logic                done_q;

    // Issue side: the address register plus a tag saying an issue just happened
    logic                issue_vld_q;
    logic [15:0]         issue_idx_q;
    logic                issuing_q;
    logic [15:0]         next_idx_q;
    logic [15:0]         issue_hold_q;

    // Output side: hold countdown for the index currently presented
    logic [15:0]         out_hold_q;

    // Valid/index shift pipeline matching the RAM read latency
    logic                pipe_vld_q [1:RAM_LATENCY];
    logic [15:0]         pipe_idx_q [1:RAM_LATENCY];

    logic                issue_now_d;
    logic [15:0]         count_d;
    logic                emerge_vld;
    logic [15:0]         emerge_idx;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] next_index(input logic [15:0] i);
        return (i == LAST_IDX) ? 16'd0 : i + 16'd1;
    endfunction

    assign emerge_vld = pipe_vld_q[RAM_LATENCY];
    assign emerge_idx = pipe_idx_q[RAM_LATENCY];

    // Next-state helpers: when to issue the next address, and the strobe count
    always_comb begin
        issue_now_d = (state_q == S_STREAM) && issuing_q && (issue_hold_q == 16'd0);
        count_d     = count_q;
        if (busy_q && data_good) begin
            count_d = sat_inc16(count_q);
        end
    end

    // Pass FSM, issue side, read pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            value_q      <= '0;
            index_q      <= IDLE_IDX;
            sbf_q        <= 1'b0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            issue_vld_q  <= 1'b0;
            issue_idx_q  <= '0;
            issuing_q    <= 1'b0;
            next_idx_q   <= '0;
            issue_hold_q <= '0;
            out_hold_q   <= '0;
            for (int k = 1; k <= RAM_LATENCY; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_idx_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[1] <= issue_vld_q;
            pipe_idx_q[1] <= issue_idx_q;
            for (int k = 2; k <= RAM_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_idx_q[k] <= pipe_idx_q[k-1];
            end
            issue_vld_q <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= count_d;

            if (out_hold_q != 16'd0) begin
                out_hold_q <= out_hold_q - 16'd1;
            end

            // A read returns: present it and start its hold window
            if (emerge_vld) begin
                value_q    <= sample_data;
                index_q    <= emerge_idx;
                out_hold_q <= HOLD_LAST;
                sbf_q      <= 1'b1;
`ifdef SAMPLE_STREAMER_WRAP_EN
                // Index 0 following a shown index marks a wrap: new pass begins
                if (emerge_idx == 16'd0 && index_q != IDLE_IDX) begin
                    done_q  <= 1'b1;
                    count_q <= data_good ? 16'd1 : 16'd0;
                end
`endif
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_STREAM;
                        busy_q       <= 1'b1;
                        count_q      <= '0;
                        addr_q       <= '0;
                        issue_vld_q  <= 1'b1;
                        issue_idx_q  <= '0;
                        next_idx_q   <= next_index(16'd0);
                        issue_hold_q <= HOLD_LAST;
`ifdef SAMPLE_STREAMER_WRAP_EN
                        issuing_q    <= 1'b1;
`else
                        issuing_q    <= (NUM_SAMPLES > 1);
`endif
                    end
                end
                S_STREAM: begin
                    if (issue_now_d) begin
                        addr_q       <= next_idx_q[ADDR_W-1:0];
                        issue_vld_q  <= 1'b1;
                        issue_idx_q  <= next_idx_q;
                        next_idx_q   <= next_index(next_idx_q);
                        issue_hold_q <= HOLD_LAST;
`ifndef SAMPLE_STREAMER_WRAP_EN
                        if (next_idx_q == LAST_IDX) begin
                            issuing_q <= 1'b0;
                        end
`endif
                    end else if (issuing_q && issue_hold_q != 16'd0) begin
                        issue_hold_q <= issue_hold_q - 16'd1;
                    end
`ifndef SAMPLE_STREAMER_WRAP_EN
                    // Final index has finished its hold and nothing is in flight
                    if (index_q == LAST_IDX && out_hold_q == 16'd0 && !emerge_vld) begin
                        state_q <= S_DRAIN;
                    end
`endif
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    sbf_q   <= 1'b0;
                    index_q <= IDLE_IDX;
                    value_q <= '0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sample_addr     = addr_q;
    assign output_value    = value_q;
    assign output_index    = index_q;
    assign startbeamformer = sbf_q;
    assign select_count    = count_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_sample_index_streamer.sv
// Scoreboard bench for sample_index_streamer: stimulus pushes expected
// presentations/done events; a monitor pops and compares as the DUT emits them.
`timescale 1ns/1ps
module tb_sample_index_streamer;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;
`ifdef SAMPLE_STREAMER_WRAP_EN
    localparam int N = 4;
`else
    localparam int N = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic dg_a = 1'b0, dg_b = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;

    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [31:0]       data_a, data_b, val_a, val_b;
    logic [15:0]       idx_a, idx_b, cnt_a, cnt_b;
    logic              sbf_a, sbf_b, busy_a, busy_b, done_a, done_b;

    sample_index_streamer #(.NUM_SAMPLES(N), .ADDR_W(ADDR_W), .RAM_LATENCY(LAT), .HOLD_CYCLES(1)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .sample_addr(addr_a), .sample_data(data_a),
        .output_value(val_a), .output_index(idx_a), .startbeamformer(sbf_a), .data_good(dg_a),
        .select_count(cnt_a), .busy(busy_a), .done(done_a));

    sample_index_streamer #(.NUM_SAMPLES(N), .ADDR_W(ADDR_W), .RAM_LATENCY(LAT), .HOLD_CYCLES(3)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .sample_addr(addr_b), .sample_data(data_b),
        .output_value(val_b), .output_index(idx_b), .startbeamformer(sbf_b), .data_good(dg_b),
        .select_count(cnt_b), .busy(busy_b), .done(done_b));

    // Sample RAM models: data = addr*3, LAT cycles after the address
    logic [31:0] ram_a [0:LAT-1];
    logic [31:0] ram_b [0:LAT-1];
    always @(posedge clk) begin
        ram_a[0] <= 32'(addr_a) * 32'd3;
        ram_b[0] <= 32'(addr_b) * 32'd3;
        for (int k = 1; k < LAT; k++) begin
            ram_a[k] <= ram_a[k-1];
            ram_b[k] <= ram_b[k-1];
        end
    end
    assign data_a = ram_a[LAT-1];
    assign data_b = ram_b[LAT-1];

    // cyc = number of the most recent rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [15:0] idx; logic [31:0] val; } pres_t;
    typedef struct { int cyc; logic [15:0] cnt; } done_t;
    pres_t pq [2][$];
    done_t dq [2][$];
    logic [15:0] prev_idx [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int u, input logic [15:0] idx, input logic [31:0] val, input logic sbf,
                       input logic dn, input logic [15:0] cnt, input logic bsy);
        pres_t e;
        done_t d;
        if (idx != prev_idx[u] && idx != 16'hFFFF) begin
            if (pq[u].size() == 0) begin
                chk($sformatf("unexpected_index_u%0d", u), 32'(idx), 32'hFFFF);
            end else begin
                e = pq[u].pop_front();
                chk($sformatf("present_cycle_u%0d", u), 32'(cyc), 32'(e.cyc));
                chk($sformatf("present_index_u%0d", u), 32'(idx), 32'(e.idx));
                chk($sformatf("present_value_u%0d", u), val, e.val);
                chk($sformatf("sbf_on_present_u%0d", u), 32'(sbf), 32'd1);
            end
        end
        if (dn) begin
            if (dq[u].size() == 0) begin
                chk($sformatf("unexpected_done_u%0d", u), 32'(dn), 32'd0);
            end else begin
                d = dq[u].pop_front();
                chk($sformatf("done_cycle_u%0d", u), 32'(cyc), 32'(d.cyc));
                chk($sformatf("done_count_u%0d", u), 32'(cnt), 32'(d.cnt));
`ifdef SAMPLE_STREAMER_WRAP_EN
                chk($sformatf("done_index_u%0d", u), 32'(idx), 32'd0);
                chk($sformatf("done_sbf_u%0d", u), 32'(sbf), 32'd1);
                chk($sformatf("done_busy_u%0d", u), 32'(bsy), 32'd1);
`else
                chk($sformatf("done_index_u%0d", u), 32'(idx), 32'hFFFF);
                chk($sformatf("done_sbf_u%0d", u), 32'(sbf), 32'd0);
                chk($sformatf("done_busy_u%0d", u), 32'(bsy), 32'd0);
`endif
            end
        end
        prev_idx[u] = idx;
    endtask

    // Monitor: sample 1ns after each rising edge
    always begin
        @(posedge clk);
        #1;
        mon(0, idx_a, val_a, sbf_a, done_a, cnt_a, busy_a);
        mon(1, idx_b, val_b, sbf_b, done_b, cnt_b, busy_b);
    end

    // Expected presentations of one full pass started at edge s
    task automatic push_pass(input int u, input int s, input int hold, input logic [15:0] cnt);
        for (int i = 0; i < N; i++) begin
            pq[u].push_back('{cyc: s + 3 + i * hold, idx: 16'(i), val: 32'(i * 3)});
        end
        dq[u].push_back('{cyc: s + 3 + N * hold + 1, cnt: cnt});
    endtask

    // Return at the falling edge just before rising edge c
    task automatic at_cycle(input int c);
        while (cyc < c - 1) @(negedge clk);
    endtask

    task automatic drive_start(input int u, input int c);
        at_cycle(c);
        if (u == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_dg(input int c);
        at_cycle(c);
        dg_a = 1'b1;
        @(negedge clk);
        dg_a = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(addr_a), 32'd0);
        chk({tag, "_value"}, val_a, 32'd0);
        chk({tag, "_index"}, 32'(idx_a), 32'hFFFF);
        chk({tag, "_sbf"}, 32'(sbf_a), 32'd0);
        chk({tag, "_count"}, 32'(cnt_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        int s1, s2, s3, s4, s5;
        prev_idx[0] = 16'hFFFF;
        prev_idx[1] = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

`ifdef SAMPLE_STREAMER_WRAP_EN
        // Continuous pass: three wraps worth of indices, done at each later index 0
        s1 = cyc + 2;
        for (int i = 0; i < 3 * N; i++) begin
            pq[0].push_back('{cyc: s1 + 3 + i, idx: 16'(i % N), val: 32'((i % N) * 3)});
        end
        dq[0].push_back('{cyc: s1 + 3 + N, cnt: 16'd0});
        dq[0].push_back('{cyc: s1 + 3 + 2 * N, cnt: 16'd0});
        drive_start(0, s1);
        at_cycle(s1 + 3 + 3 * N);
        chk("wrap_sbf_held", 32'(sbf_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("wrap_reset");
`else
        // data_good in IDLE is ignored
        pulse_dg(cyc + 2);
        @(negedge clk);
        chk("idle_dg_ignored", 32'(cnt_a), 32'd0);

        // Pass 1 (HOLD=1) with a start re-pulse mid-pass that must be ignored
        s1 = cyc + 2;
        push_pass(0, s1, 1, 16'd0);
        drive_start(0, s1);
        drive_start(0, s1 + 6);

        // Pass 2 started on the done cycle; data_good after indices 2, 5, 7
        s2 = s1 + 13;
        push_pass(0, s2, 1, 16'd3);
        drive_start(0, s2);
        pulse_dg(s2 + 7);
        pulse_dg(s2 + 10);
        at_cycle(s2 + 12);
        chk("drain_index", 32'(idx_a), 32'd7);
        chk("drain_value", val_a, 32'd21);
        chk("drain_sbf", 32'(sbf_a), 32'd1);
        chk("drain_busy", 32'(busy_a), 32'd1);
        dg_a = 1'b1;
        @(negedge clk);
        dg_a = 1'b0;
        // data_good in DONE must not move the frozen count
        pulse_dg(cyc + 2);
        @(negedge clk);
        chk("count_frozen", 32'(cnt_a), 32'd3);

        // Pass 3: reset while index 4 is shown
        s3 = cyc + 2;
        for (int i = 0; i <= 4; i++) begin
            pq[0].push_back('{cyc: s3 + 3 + i, idx: 16'(i), val: 32'(i * 3)});
        end
        drive_start(0, s3);
        pulse_dg(s3 + 6);
        at_cycle(s3 + 8);
        chk("pre_reset_index", 32'(idx_a), 32'd4);
        chk("pre_reset_count", 32'(cnt_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midpass_reset");

        // Pass 4: restarts cleanly from index 0 with a zero count
        s4 = cyc + 2;
        push_pass(0, s4, 1, 16'd0);
        drive_start(0, s4);

        // Pass on the HOLD=3 instance
        s5 = s4 + 16;
        push_pass(1, s5, 3, 16'd0);
        drive_start(1, s5);
        at_cycle(s5 + 3);
        chk("hold3_addr_before", 32'(addr_b), 32'd0);
        @(negedge clk);
        chk("hold3_addr_step1", 32'(addr_b), 32'd1);
        at_cycle(s5 + 7);
        chk("hold3_addr_step2", 32'(addr_b), 32'd2);
        at_cycle(s5 + 3 + N * 3 + 4);
        chk("hold3_idle_index", 32'(idx_b), 32'hFFFF);
`endif
        repeat (3) @(negedge clk);
        chk("pending_presentations_u0", 32'(pq[0].size()), 32'd0);
        chk("pending_presentations_u1", 32'(pq[1].size()), 32'd0);
        chk("pending_done_u0", 32'(dq[0].size()), 32'd0);
        chk("pending_done_u1", 32'(dq[1].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
